// File: rtl/riscv_multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : riscv_multicycle_ctrl_if
// Description : Control bundle between the multicycle control FSM and the
//               datapath (IR fields, ALU flags, memory handshake, selects).
// Revision    : 1.0 - initial release
// ============================================================================
interface riscv_multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic             Zero;
  logic             Negative;
  logic             mem_ready;

  logic             PCWrite;
  logic             AdrSrc;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic [1:0]       ResultSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [2:0]       ImmSrc;
  logic             RegWrite;
  logic             illegal;
  logic [3:0]       state;
  logic [CNT_W-1:0] instret;

  // Controller side
  modport master (
    input  op, funct3, Zero, Negative, mem_ready,
    output PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUOp, ImmSrc, RegWrite, illegal, state, instret
  );

  // Datapath side
  modport slave (
    output op, funct3, Zero, Negative, mem_ready,
    input  PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUOp, ImmSrc, RegWrite, illegal, state, instret
  );
endinterface
`default_nettype wire

// File: rtl/riscv_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : riscv_multicycle_ctrl
// Description : Main control FSM of the multicycle RV32I core; sequences the
//               shared ALU/memory/register file and counts retired instrs.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  riscv_multicycle_ctrl_if.master    bus
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_EXEC_I   = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_JALR     = 4'd11;
  localparam logic [3:0] S_UPPER    = 4'd12;
  localparam logic [3:0] S_LINK     = 4'd13;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             taken;
  logic             retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    taken = 1'b0;
    case (bus.funct3)
      3'b000:  taken = bus.Zero;
      3'b001:  taken = ~bus.Zero;
      3'b100:  taken = bus.Negative;
      3'b101:  taken = ~bus.Negative;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_ITYPE:          state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI, OP_AUIPC:  state_d = S_UPPER;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXEC_R:   state_d = S_ALUWB;
      S_EXEC_I:   state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_JALR:     state_d = S_LINK;
      S_LINK:     state_d = S_ALUWB;
      S_UPPER:    state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase

    // The illegal DECODE->FETCH path is deliberately excluded from retirement
    retire = (state_d == S_FETCH) &&
             ((state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
              (state_q == S_ALUWB) || (state_q == S_BRANCH) ||
              (state_q == S_UPPER));
    instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};
  end

  always_comb begin
    bus.PCWrite   = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.ResultSrc = 2'b00;
    bus.ALUSrcA   = 2'b00;
    bus.ALUSrcB   = 2'b00;
    bus.ALUOp     = 2'b00;
    bus.ImmSrc    = 3'b000;
    bus.RegWrite  = 1'b0;
    bus.illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.MemRead   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.IRWrite   = bus.mem_ready;
        bus.PCWrite   = bus.mem_ready;
      end
      S_DECODE: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
        case (bus.op)
          OP_LOAD, OP_RTYPE, OP_ITYPE, OP_JALR: bus.ImmSrc = 3'b000;
          OP_STORE:                             bus.ImmSrc = 3'b001;
          OP_BRANCH:                            bus.ImmSrc = 3'b010;
          OP_JAL:                               bus.ImmSrc = 3'b011;
          OP_LUI, OP_AUIPC:                     bus.ImmSrc = 3'b100;
          default: begin
            bus.ImmSrc  = 3'b000;
            bus.illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        bus.ImmSrc  = (bus.op == OP_STORE) ? 3'b001 : 3'b000;
      end
      S_MEMREAD: begin
        bus.AdrSrc  = 1'b1;
        bus.MemRead = 1'b1;
      end
      S_MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        bus.AdrSrc   = 1'b1;
        bus.MemWrite = 1'b1;
      end
      S_EXEC_R: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUOp   = 2'b10;
      end
      S_EXEC_I: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        bus.ALUOp   = 2'b10;
      end
      S_ALUWB:  bus.RegWrite = 1'b1;
      S_BRANCH: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUOp   = 2'b01;
        bus.PCWrite = taken;
      end
      S_JAL: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        bus.PCWrite = 1'b1;
      end
      S_JALR: begin
        bus.ALUSrcA   = 2'b10;
        bus.ALUSrcB   = 2'b01;
        bus.ResultSrc = 2'b10;
        bus.PCWrite   = 1'b1;
      end
      S_LINK: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
      end
      S_UPPER: begin
        bus.ImmSrc    = 3'b100;
        bus.RegWrite  = 1'b1;
        bus.ResultSrc = (bus.op == OP_LUI) ? 2'b11 : 2'b00;
      end
      default: ;
    endcase

    // No enable may leak out while reset is held
    if (!rst_n) begin
      bus.PCWrite  = 1'b0;
      bus.IRWrite  = 1'b0;
      bus.MemRead  = 1'b0;
      bus.MemWrite = 1'b0;
      bus.RegWrite = 1'b0;
      bus.illegal  = 1'b0;
    end
  end

  assign bus.state   = state_q;
  assign bus.instret = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_multicycle_ctrl
// Description : Self-checking bench for the multicycle control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_multicycle_ctrl;
  localparam int CNT_W = 4;

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] JR  = 7'b1100111;
  localparam logic [6:0] LUI = 7'b0110111;
  localparam logic [6:0] AUI = 7'b0010111;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  riscv_multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();
  riscv_multicycle_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  int exp_instret = 0;

  // Runs one instruction from its first FETCH cycle to the next FETCH and
  // compares the state trace and every enable event against a model built
  // from the instruction class.
  task automatic run_instr(input logic [6:0] op_v, input logic [2:0] f3,
                           input logic z, input logic n, input int wf,
                           input int wm, input string tag);
    int       trace[$];
    logic [5:0] exp_pc[$], exp_rw[$], obs_pc[$], obs_rw[$];
    int       exp_frd, exp_drd, exp_wr, exp_ill;
    int       obs_frd = 0, obs_drd = 0, obs_wr = 0, obs_ill = 0, obs_ir = 0;
    bit       known, tk;
    known = (op_v inside {LD, ST, RT, IT, BR, JL, JR, LUI, AUI});
    tk = (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z :
         (f3 == 3'b100) ? n : (f3 == 3'b101) ? !n : 1'b0;
    repeat (wf + 1) trace.push_back(0);
    trace.push_back(1);
    exp_pc.push_back({4'd0, 2'b10});
    case (op_v)
      LD:  begin trace.push_back(2); repeat (wm + 1) trace.push_back(3);
                 trace.push_back(4); exp_rw.push_back({4'd4, 2'b01}); end
      ST:  begin trace.push_back(2); repeat (wm + 1) trace.push_back(5); end
      RT:  begin trace.push_back(6); trace.push_back(8); exp_rw.push_back({4'd8, 2'b00}); end
      IT:  begin trace.push_back(7); trace.push_back(8); exp_rw.push_back({4'd8, 2'b00}); end
      BR:  begin trace.push_back(9); if (tk) exp_pc.push_back({4'd9, 2'b00}); end
      JL:  begin trace.push_back(10); trace.push_back(8);
                 exp_pc.push_back({4'd10, 2'b00}); exp_rw.push_back({4'd8, 2'b00}); end
      JR:  begin trace.push_back(11); trace.push_back(13); trace.push_back(8);
                 exp_pc.push_back({4'd11, 2'b10}); exp_rw.push_back({4'd8, 2'b00}); end
      LUI: begin trace.push_back(12); exp_rw.push_back({4'd12, 2'b11}); end
      AUI: begin trace.push_back(12); exp_rw.push_back({4'd12, 2'b00}); end
      default: ;
    endcase
    exp_frd = wf + 1;
    exp_drd = (op_v == LD) ? wm + 1 : 0;
    exp_wr  = (op_v == ST) ? wm + 1 : 0;
    exp_ill = known ? 0 : 1;
    if (known) exp_instret = (exp_instret + 1) % (1 << CNT_W);

    for (int i = 0; i < trace.size(); i++) begin
      bus.op = op_v; bus.funct3 = f3; bus.Zero = z; bus.Negative = n;
      if (trace[i] inside {0, 3, 5})
        bus.mem_ready = (i + 1 == trace.size()) || (trace[i + 1] != trace[i]);
      else
        bus.mem_ready = 1'($urandom_range(0, 1));
      #1;
      n_checks++;
      if (bus.state !== 4'(trace[i])) begin
        n_fail++;
        $display("FAIL %s state[%0d]: got %0d want %0d", tag, i, bus.state, trace[i]);
      end
      if (bus.PCWrite)  obs_pc.push_back({bus.state, bus.ResultSrc});
      if (bus.RegWrite) obs_rw.push_back({bus.state, bus.ResultSrc});
      if (bus.MemRead)  begin if (bus.AdrSrc) obs_drd++; else obs_frd++; end
      if (bus.MemWrite) begin if (bus.AdrSrc) obs_wr++; else obs_wr += 100; end
      if (bus.illegal && bus.state == 4'd1) obs_ill++;
      else if (bus.illegal) obs_ill += 100;
      if (bus.IRWrite)  obs_ir++;
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (bus.state !== 4'd0 || bus.instret !== CNT_W'(exp_instret)) begin
      n_fail++;
      $display("FAIL %s end: state=%0d instret=%0d want state=0 instret=%0d",
               tag, bus.state, bus.instret, exp_instret);
    end
    n_checks++;
    if (obs_pc.size() != exp_pc.size() || obs_rw.size() != exp_rw.size()) begin
      n_fail++;
      $display("FAIL %s event counts: pcwrite %0d regwrite %0d want %0d %0d",
               tag, obs_pc.size(), obs_rw.size(), exp_pc.size(), exp_rw.size());
    end else begin
      for (int k = 0; k < exp_pc.size(); k++) begin
        n_checks++;
        if (obs_pc[k] !== exp_pc[k]) begin
          n_fail++;
          $display("FAIL %s pcwrite[%0d] {state,ResultSrc}: got %h want %h", tag, k, obs_pc[k], exp_pc[k]);
        end
      end
      for (int k = 0; k < exp_rw.size(); k++) begin
        n_checks++;
        if (obs_rw[k] !== exp_rw[k]) begin
          n_fail++;
          $display("FAIL %s regwrite[%0d] {state,ResultSrc}: got %h want %h", tag, k, obs_rw[k], exp_rw[k]);
        end
      end
    end
    n_checks++;
    if (obs_frd != exp_frd || obs_drd != exp_drd || obs_wr != exp_wr ||
        obs_ill != exp_ill || obs_ir != 1) begin
      n_fail++;
      $display("FAIL %s mem/ir/illegal: frd=%0d drd=%0d wr=%0d ill=%0d ir=%0d want %0d %0d %0d %0d 1",
               tag, obs_frd, obs_drd, obs_wr, obs_ill, obs_ir, exp_frd, exp_drd, exp_wr, exp_ill);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.mem_ready = 1'b1; bus.op = RT; bus.funct3 = 3'b000;
    bus.Zero = 1'b0; bus.Negative = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      n_checks++;
      if (bus.state !== 4'd0 || bus.instret !== '0 || bus.PCWrite || bus.IRWrite ||
          bus.MemRead || bus.MemWrite || bus.RegWrite || bus.illegal) begin
        n_fail++;
        $display("FAIL reset_hold: state=%0d instret=%0d en=%b%b%b%b%b%b want 0 0 000000",
                 bus.state, bus.instret, bus.PCWrite, bus.IRWrite, bus.MemRead,
                 bus.MemWrite, bus.RegWrite, bus.illegal);
      end
    end
    @(negedge clk);
    rst_n = 1'b1; #1;
    n_checks++;
    if (bus.MemRead !== 1'b1 || bus.AdrSrc !== 1'b0 || bus.ALUSrcB !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_release: MemRead=%b AdrSrc=%b ALUSrcB=%b want 1 0 10",
               bus.MemRead, bus.AdrSrc, bus.ALUSrcB);
    end
    exp_instret = 0;
  endtask

  task automatic test_rtype();
    run_instr(RT, 3'b000, 1'b0, 1'b0, 0, 0, "rtype");
    run_instr(IT, 3'b111, 1'b1, 1'b0, 1, 0, "itype_fetchwait");
  endtask

  task automatic test_load_wait();
    run_instr(LD, 3'b010, 1'b0, 1'b0, 0, 2, "load_wait2");
    run_instr(ST, 3'b010, 1'b0, 1'b0, 0, 1, "store_wait1");
  endtask

  task automatic test_branch_sweep();
    logic [2:0] f3s [5];
    f3s[0] = 3'b000; f3s[1] = 3'b001; f3s[2] = 3'b100; f3s[3] = 3'b101; f3s[4] = 3'b110;
    for (int f = 0; f < 5; f++)
      for (int c = 0; c < 4; c++)
        run_instr(BR, f3s[f], c[0], c[1], 0, 0, "branch");
  endtask

  task automatic test_jumps();
    run_instr(JR, 3'b000, 1'b0, 1'b0, 0, 0, "jalr");
    run_instr(JL, 3'b000, 1'b0, 1'b0, 0, 0, "jal");
    run_instr(AUI, 3'b000, 1'b0, 1'b0, 0, 0, "auipc");
  endtask

  task automatic test_illegal();
    run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, "illegal");
  endtask

  task automatic test_random();
    logic [6:0] ops [11];
    ops[0] = LD; ops[1] = ST; ops[2] = RT; ops[3] = IT; ops[4] = BR; ops[5] = JL;
    ops[6] = JR; ops[7] = LUI; ops[8] = AUI; ops[9] = 7'b1111111; ops[10] = 7'b0000000;
    for (int k = 0; k < 60; k++)
      run_instr(ops[$urandom_range(0, 10)], 3'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 2), "random");
  endtask

  task automatic test_wrap();
    while (exp_instret != (1 << CNT_W) - 1)
      run_instr(LUI, 3'b000, 1'b0, 1'b0, 0, 0, "wrap_fill");
    n_checks++;
    if (bus.instret !== {CNT_W{1'b1}}) begin
      n_fail++;
      $display("FAIL wrap_allones: instret=%0d want %0d", bus.instret, (1 << CNT_W) - 1);
    end
    run_instr(LUI, 3'b000, 1'b0, 1'b0, 0, 0, "wrap");
    n_checks++;
    if (bus.instret !== '0) begin
      n_fail++;
      $display("FAIL wrap_zero: instret=%0d want 0", bus.instret);
    end
  endtask

  task automatic test_reset_mid();
    bus.op = RT; bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (bus.state !== 4'd6) begin
      n_fail++;
      $display("FAIL mid_setup: state=%0d want 6", bus.state);
    end
    rst_n = 1'b0; #1;
    n_checks++;
    if (bus.state !== 4'd0 || bus.instret !== '0 || bus.PCWrite || bus.IRWrite ||
        bus.MemRead || bus.RegWrite || bus.MemWrite || bus.illegal) begin
      n_fail++;
      $display("FAIL mid_reset: state=%0d instret=%0d MemRead=%b PCWrite=%b want 0 0 0 0",
               bus.state, bus.instret, bus.MemRead, bus.PCWrite);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_instret = 0;
    run_instr(LUI, 3'b000, 1'b0, 1'b0, 0, 0, "after_mid_reset");
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_wait();
    test_branch_sweep();
    test_jumps();
    test_illegal();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
